// File: rtl/sl3_rx_demux_if.sv
// Word-stream bundle used for the SL3 RX input and for each engine output stream.
// The metadata field is only meaningful on the RX side; the outputs tie it to zero.
interface sl3_rx_demux_if #(
    parameter int DATA_W = 128,
    parameter int META_W = 16
);
    logic [DATA_W-1:0] data;
    logic [META_W-1:0] meta;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, meta, last, valid, input ready);
    modport slave  (input data, meta, last, valid, output ready);
endinterface

// File: rtl/sl3_rx_demux.sv
// SL3 receive demultiplexer: routes each packet by its first-word metadata to one of
// four engine streams through 2-entry skid buffers, checking length and counting packets.
module sl3_rx_demux #(
    parameter int DATA_W   = 128,
    parameter int META_W   = 16,
    parameter int PKT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_core_i,
    input  logic [PKT_BITS-1:0] data_pkt_numcls_m1_i,
    input  logic [PKT_BITS-1:0] tw_pkt_numcls_m1_i,
    input  logic [PKT_BITS-1:0] tf_pkt_numcls_m1_i,
    input  logic [PKT_BITS-1:0] res_pkt_numcls_m1_i,
    sl3_rx_demux_if.slave       rx_i,
    sl3_rx_demux_if.master      data_o,
    sl3_rx_demux_if.master      tw_o,
    sl3_rx_demux_if.master      tf_o,
    sl3_rx_demux_if.master      res_o,
    output logic [31:0]         num_rx_packets_o,
    output logic [31:0]         num_drop_packets_o,
    output logic                len_error_o
);
    localparam int NSTR = 4;

    localparam logic [META_W-1:0] META_DATA = META_W'(2'd0);
    localparam logic [META_W-1:0] META_TW   = META_W'(2'd1);
    localparam logic [META_W-1:0] META_TF   = META_W'(2'd2);
    localparam logic [META_W-1:0] META_RES  = META_W'(2'd3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    // Returns {known, stream index}.
    function automatic logic [2:0] decode_meta(input logic [META_W-1:0] meta);
        logic [2:0] res;
        case (meta)
            META_DATA: res = 3'b100;
            META_TW:   res = 3'b101;
            META_TF:   res = 3'b110;
            META_RES:  res = 3'b111;
            default:   res = 3'b000;
        endcase
        return res;
    endfunction

    state_e                          state_q, state_d;
    logic [1:0]                      dest_q;
    logic [PKT_BITS-1:0]             m1_q;
    logic [PKT_BITS-1:0]             line_q;
    logic [31:0]                     rx_cnt_q;
    logic [31:0]                     drop_cnt_q;
    logic                            len_err_q;

    logic [2:0]                      dec_s;
    logic [NSTR-1:0][PKT_BITS-1:0]   numcls_s;
    logic [1:0]                      sel_dest_s;
    logic [PKT_BITS-1:0]             sel_m1_s;
    logic [PKT_BITS-1:0]             word_idx_s;
    logic                            rx_ready_s;
    logic                            route_s;
    logic                            drop_hdr_s;
    logic                            len_bad_s;
    logic [NSTR-1:0]                 out_ready_s;
    logic [NSTR-1:0]                 buf_full_s;
    logic [NSTR-1:0]                 buf_valid_s;
    logic [NSTR-1:0][DATA_W:0]       buf_head_s;

    assign dec_s    = decode_meta(rx_i.meta);
    assign numcls_s = {res_pkt_numcls_m1_i, tf_pkt_numcls_m1_i,
                       tw_pkt_numcls_m1_i, data_pkt_numcls_m1_i};

    // Destination, expected length and word index that apply to the word on the bus.
    always_comb begin
        sel_dest_s = dest_q;
        sel_m1_s   = m1_q;
        word_idx_s = line_q;
        if (state_q == ST_IDLE) begin
            sel_dest_s = dec_s[1:0];
            sel_m1_s   = numcls_s[dec_s[1:0]];
            word_idx_s = {PKT_BITS{1'b0}};
        end else begin
            sel_dest_s = dest_q;
            sel_m1_s   = m1_q;
            word_idx_s = line_q;
        end
    end

    // Packet FSM next state and RX handshake.
    always_comb begin
        state_d    = state_q;
        rx_ready_s = 1'b1;
        route_s    = 1'b0;
        drop_hdr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_i.valid) begin
                    if (dec_s[2]) begin
                        rx_ready_s = ~buf_full_s[dec_s[1:0]];
                        if (!buf_full_s[dec_s[1:0]]) begin
                            route_s = 1'b1;
                            state_d = rx_i.last ? ST_IDLE : ST_ROUTE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        drop_hdr_s = 1'b1;
                        state_d    = rx_i.last ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                rx_ready_s = ~buf_full_s[dest_q];
                if (rx_i.valid && !buf_full_s[dest_q]) begin
                    route_s = 1'b1;
                    state_d = rx_i.last ? ST_IDLE : ST_ROUTE;
                end else begin
                    state_d = ST_ROUTE;
                end
            end
            ST_DROP: begin
                if (rx_i.valid && rx_i.last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A short packet ends before the last expected word; a long one misses last on it.
    assign len_bad_s   = route_s & (rx_i.last ? (word_idx_s != sel_m1_s)
                                              : (word_idx_s == sel_m1_s));
    assign rx_i.ready  = rx_ready_s;

    // FSM state, locked destination, line counter, statistics and sticky length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dest_q     <= 2'd0;
            m1_q       <= {PKT_BITS{1'b0}};
            line_q     <= {PKT_BITS{1'b0}};
            rx_cnt_q   <= 32'd0;
            drop_cnt_q <= 32'd0;
            len_err_q  <= 1'b0;
        end else if (start_core_i) begin
            state_q    <= ST_IDLE;
            dest_q     <= 2'd0;
            m1_q       <= {PKT_BITS{1'b0}};
            line_q     <= {PKT_BITS{1'b0}};
            rx_cnt_q   <= 32'd0;
            drop_cnt_q <= 32'd0;
            len_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (route_s) begin
                line_q <= rx_i.last ? {PKT_BITS{1'b0}}
                                    : word_idx_s + {{(PKT_BITS-1){1'b0}}, 1'b1};
                if (state_q == ST_IDLE) begin
                    dest_q <= sel_dest_s;
                    m1_q   <= sel_m1_s;
                end
                if (rx_i.last) begin
                    rx_cnt_q <= rx_cnt_q + 32'd1;
                end
            end
            if (drop_hdr_s) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
            if (len_bad_s) begin
                len_err_q <= 1'b1;
            end
        end
    end

    assign num_rx_packets_o   = rx_cnt_q;
    assign num_drop_packets_o = drop_cnt_q;
    assign len_error_o        = len_err_q;

    for (genvar g = 0; g < NSTR; g++) begin : g_buf
        logic [DATA_W:0] mem0_q;
        logic [DATA_W:0] mem1_q;
        logic [1:0]      cnt_q;
        logic            push_s;
        logic            pop_s;

        assign push_s = route_s && (sel_dest_s == 2'(g));
        assign pop_s  = (cnt_q != 2'd0) && out_ready_s[g];

        // Two-entry skid buffer; the head entry (mem0) always drives the output.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem0_q <= {(DATA_W+1){1'b0}};
                mem1_q <= {(DATA_W+1){1'b0}};
                cnt_q  <= 2'd0;
            end else if (start_core_i) begin
                cnt_q <= 2'd0;
            end else begin
                case ({push_s, pop_s})
                    2'b10: begin
                        if (cnt_q == 2'd0) begin
                            mem0_q <= {rx_i.last, rx_i.data};
                        end else begin
                            mem1_q <= {rx_i.last, rx_i.data};
                        end
                        cnt_q <= cnt_q + 2'd1;
                    end
                    2'b01: begin
                        mem0_q <= mem1_q;
                        cnt_q  <= cnt_q - 2'd1;
                    end
                    2'b11: begin
                        mem0_q <= {rx_i.last, rx_i.data};
                    end
                    default: begin
                        cnt_q <= cnt_q;
                    end
                endcase
            end
        end

        assign buf_full_s[g]  = (cnt_q == 2'd2);
        assign buf_valid_s[g] = (cnt_q != 2'd0);
        assign buf_head_s[g]  = mem0_q;
    end

    assign out_ready_s = {res_o.ready, tf_o.ready, tw_o.ready, data_o.ready};

    assign data_o.data  = buf_head_s[0][DATA_W-1:0];
    assign data_o.last  = buf_head_s[0][DATA_W];
    assign data_o.valid = buf_valid_s[0];
    assign data_o.meta  = {META_W{1'b0}};
    assign tw_o.data    = buf_head_s[1][DATA_W-1:0];
    assign tw_o.last    = buf_head_s[1][DATA_W];
    assign tw_o.valid   = buf_valid_s[1];
    assign tw_o.meta    = {META_W{1'b0}};
    assign tf_o.data    = buf_head_s[2][DATA_W-1:0];
    assign tf_o.last    = buf_head_s[2][DATA_W];
    assign tf_o.valid   = buf_valid_s[2];
    assign tf_o.meta    = {META_W{1'b0}};
    assign res_o.data   = buf_head_s[3][DATA_W-1:0];
    assign res_o.last   = buf_head_s[3][DATA_W];
    assign res_o.valid  = buf_valid_s[3];
    assign res_o.meta   = {META_W{1'b0}};
endmodule
